// File: rtl/ready_valid_burst_receiver.sv
// rtl/ready_valid_burst_receiver.sv - armed MAX_VAL+1 beat receiver with 2-entry output buffer
// Optional BURST_SEQ_CHECK_EN adds a sticky in_data vs beat-index mismatch flag on seq_err.
module ready_valid_burst_receiver #(
  parameter int WIDTH   = 2,
  parameter int MAX_VAL = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] beat_count,
  output logic             seq_err
);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_DRAIN, S_DONE} state_t;

  localparam logic [WIDTH-1:0] LAST_BEAT = WIDTH'(MAX_VAL);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q;
  logic [WIDTH-1:0] beat_count_q;
  logic             push, pop;

  // in_ready looks only at registered occupancy, so a same-cycle pop never frees a slot
  assign in_ready   = (state_q == S_RECV) && (count_q != 2'd2);
  assign out_valid  = (count_q != 2'd0);
  assign out_data   = mem_q[rd_ptr_q];
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign busy       = (state_q == S_RECV) || (state_q == S_DRAIN);
  assign done       = (state_q == S_DONE);
  assign beat_count = beat_count_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (go) state_d = S_RECV;
      S_RECV:  if (push && (beat_count_q == LAST_BEAT)) state_d = S_DRAIN;
      // leave DRAIN as soon as this cycle's pop empties the buffer
      S_DRAIN: if ((count_q == 2'd0) || ((count_q == 2'd1) && pop)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      mem_q[0]     <= '0;
      mem_q[1]     <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      beat_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (push) begin
        mem_q[wr_ptr_q] <= in_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
      if ((state_q == S_IDLE) && go) beat_count_q <= '0;
      else if (push)                 beat_count_q <= beat_count_q + 1'b1;
    end
  end

`ifdef BURST_SEQ_CHECK_EN
  logic seq_err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seq_err_q <= 1'b0;
    end else if ((state_q == S_IDLE) && go) begin
      seq_err_q <= 1'b0;
    end else if (push && (in_data != beat_count_q)) begin
      seq_err_q <= 1'b1;
    end
  end

  assign seq_err = seq_err_q;
`else
  assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_ready_valid_burst_receiver.sv
// tb/tb_ready_valid_burst_receiver.sv - randomized bench for ready_valid_burst_receiver vs burst-level model
module tb_ready_valid_burst_receiver;
  localparam int W  = 2;
  localparam int MV = 3;
  localparam int N  = MV + 1;

  logic         clk = 1'b0;
  logic         rst_n, go, in_valid, out_ready;
  logic [W-1:0] in_data;
  logic         in_ready, out_valid, busy, done, seq_err;
  logic [W-1:0] out_data, beat_count;

  ready_valid_burst_receiver #(.WIDTH(W), .MAX_VAL(MV)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done), .beat_count(beat_count), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: phase 0 idle, 1 burst in flight, 2 completion cycle
  int q[$];
  int phase = 0;
  int acc   = 0;
  bit bad   = 1'b0;
  int done_seen = 0;
  int pops      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_flush();
    q.delete();
    phase = 0;
    acc   = 0;
    bad   = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; go = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_flush();
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_beat_count", beat_count, 0);
    check("rst_seq_err", seq_err, 0);
  endtask

  // One clock: drive inputs after the edge, check at negedge, then advance the model
  task automatic cycle(input bit g, input bit iv, input bit orr, input bit corrupt);
    int dval;
    bit exp_ir, acc_ev, pop_ev, exp_se;
    @(posedge clk); #1;
    dval = (acc + (corrupt ? 1 : 0)) % (1 << W);
    go = g; in_valid = iv; out_ready = orr; in_data = W'(dval);
    @(negedge clk);
    exp_ir = (phase == 1) && (acc < N) && (q.size() < 2);
`ifdef BURST_SEQ_CHECK_EN
    exp_se = bad;
`else
    exp_se = 1'b0;
`endif
    check("in_ready", in_ready, exp_ir);
    check("out_valid", out_valid, q.size() > 0);
    if (q.size() > 0) check("out_data", out_data, q[0]);
    check("busy", busy, phase == 1);
    check("done", done, phase == 2);
    check("beat_count", beat_count, acc % (1 << W));
    check("seq_err", seq_err, exp_se);
    if (done === 1'b1) done_seen++;
    acc_ev = iv && exp_ir;
    pop_ev = (q.size() > 0) && orr;
    case (phase)
      0: if (g) begin phase = 1; acc = 0; bad = 1'b0; end
      1: begin
        if (pop_ev) begin void'(q.pop_front()); pops++; end
        if (acc_ev) begin
          if (dval != acc) bad = 1'b1;
          q.push_back(dval);
          acc++;
        end
        if (acc == N && q.size() == 0) phase = 2;
      end
      default: phase = 0;
    endcase
  endtask

  // p_valid < 0 selects the 1,0,0 in_valid pattern; corrupt_idx -2 = random, -1 = none
  task automatic run_burst(input int p_valid, input int p_ready, input int hold_off,
                           input bit hold_go, input int corrupt_idx, input int stop_after);
    int  k;
    bit  iv, orr, cor;
    done_seen = 0;
    pops      = 0;
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    k = 0;
    while (phase != 0 && k < 300) begin
      if (stop_after >= 0 && acc >= stop_after) return;
      iv  = (p_valid < 0) ? (k % 3 == 0) : ($urandom_range(99) < p_valid);
      orr = (k < hold_off) ? 1'b0 : ($urandom_range(99) < p_ready);
      cor = (corrupt_idx == -2) ? ($urandom_range(3) == 0) : (corrupt_idx == acc);
      cycle(hold_go, iv, orr, cor);
      k++;
    end
    check("burst_timeout", phase, 0);
    check("done_pulses", done_seen, 1);
    check("beats_out", pops, N);
  endtask

  initial begin
    rst_n = 1'b0; go = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    do_reset();

    // basic back-to-back burst
    run_burst(100, 100, 0, 1'b0, -1, -1);
    check("basic_beat_count_wrap", beat_count, 0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);

    // downstream stalled for a while, then released
    run_burst(100, 100, 6, 1'b0, -1, -1);

    // upstream gaps
    run_burst(-1, 100, 0, 1'b0, -1, -1);

    // go held high: one done per burst, immediate re-arm from IDLE
    run_burst(100, 100, 0, 1'b1, -1, -1);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    check("rearm_busy", phase, 1);
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0);

    // sequence mismatch 0,2,2,3
    run_burst(100, 100, 0, 1'b0, 1, -1);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0);

    // reset after two beats with buffer stalled
    run_burst(100, 0, 0, 1'b0, -1, 2);
    do_reset();
    done_seen = 0;
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
    check("no_done_after_reset", done_seen, 0);

    // randomized bursts
    for (int b = 0; b < 40; b++)
      run_burst($urandom_range(30, 100), $urandom_range(20, 100), $urandom_range(0, 4),
                $urandom_range(1) == 1, -2, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
